mul8_acc_stage: RTL

- Sequential stage directly downstream of the mul8 approximate 8x8 multipliers.
- Consumes the 16-bit products they emit over a valid/ready handshake and sums a group of products into a wide accumulator.
- The group is a dot-product term set, closed by a last flag or a term-count limit.
- Presents one result per group to the consumer, with an overflow indication.

---
 rtl/mul8_acc_pkg.sv | 14 +
 rtl/mul8_acc_stage_if.sv | 30 +++
 rtl/mul8_acc_add.sv | 25 ++
 rtl/mul8_acc_stage.sv | 99 +++++++++
 4 files changed

// File: rtl/mul8_acc_pkg.sv
// Shared types and constants for the mul8 product accumulator stage.
package mul8_acc_pkg;

  localparam int PROD_W        = 16;
  localparam int ACC_W_DEF     = 24;
  localparam int MAX_TERMS_DEF = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/mul8_acc_stage_if.sv
// Product-in / group-result-out handshake bundle for mul8_acc_stage.
interface mul8_acc_stage_if
  import mul8_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = $clog2(MAX_TERMS_DEF + 1)
);

  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_data;
  logic              prod_last;
  logic              acc_valid;
  logic              acc_ready;
  logic [ACC_W-1:0]  acc_data;
  logic [CNT_W-1:0]  acc_count;
  logic              acc_ovf;

  // master: product source and result consumer; slave: the accumulator stage
  modport master (
    output prod_valid, prod_data, prod_last, acc_ready,
    input  prod_ready, acc_valid, acc_data, acc_count, acc_ovf
  );

  modport slave (
    input  prod_valid, prod_data, prod_last, acc_ready,
    output prod_ready, acc_valid, acc_data, acc_count, acc_ovf
  );

endinterface

// File: rtl/mul8_acc_add.sv
// Accumulator adder with carry-out; MUL8_ACC_SAT_EN clamps the sum to all-ones on carry.
module mul8_acc_add
  import mul8_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] full_sum;

  assign full_sum = {1'b0, acc} + (ACC_W + 1)'(prod);
  assign carry    = full_sum[ACC_W];

`ifdef MUL8_ACC_SAT_EN
  // Once clamped, any further nonzero product carries again, so the sum stays pinned.
  assign sum = carry ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
  assign sum = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/mul8_acc_stage.sv
// Sums groups of mul8 products (closed by last or MAX_TERMS) and presents one result per group.
// Optional build macro MUL8_ACC_SAT_EN selects saturating instead of wrapping accumulation.
module mul8_acc_stage
  import mul8_acc_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_TERMS = MAX_TERMS_DEF,
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  mul8_acc_stage_if.slave  bus
);

  localparam bit SINGLE_TERM = (MAX_TERMS == 1);

  acc_state_e       state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             ovf_reg, ovf_next;
  logic             valid_reg, valid_next;

  logic             prod_ready;
  logic             in_xfer;
  logic             out_xfer;
  logic [CNT_W-1:0] count_inc;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;

  mul8_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc   (acc_reg),
    .prod  (bus.prod_data),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign prod_ready = (state_reg != HOLD);
  assign in_xfer    = bus.prod_valid && prod_ready;
  assign out_xfer   = valid_reg && bus.acc_ready;
  assign count_inc  = count_reg + CNT_W'(1);

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (in_xfer) begin
          acc_next   = ACC_W'(bus.prod_data);
          count_next = CNT_W'(1);
          ovf_next   = 1'b0;
          state_next = (bus.prod_last || SINGLE_TERM) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (in_xfer) begin
          acc_next   = add_sum;
          count_next = count_inc;
          if (add_carry) begin
            ovf_next = 1'b1;
          end
          state_next = (bus.prod_last || (count_inc == CNT_W'(MAX_TERMS))) ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_xfer) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // acc_valid is registered by tracking entry into HOLD one cycle ahead.
    valid_next = (state_next == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      valid_reg <= valid_next;
    end
  end

  assign bus.prod_ready = prod_ready;
  assign bus.acc_valid  = valid_reg;
  assign bus.acc_data   = acc_reg;
  assign bus.acc_count  = count_reg;
  assign bus.acc_ovf    = ovf_reg;

endmodule
